code_stimulus_gen: RTL and testbench

- Sequential 4-bit code generator directly upstream of the 4-input/4-output code converter.
- Drives the converter inputs a,b,c,d with a stepped code sequence at a programmable rate, one code per step.
- Supports binary (0..15) or BCD (0..9) ranges, up/down counting, parallel load, and free-running or single-sweep operation.
- Provides step/wrap strobes so downstream checking logic can sample converter outputs.

---
 rtl/code_stimulus_gen.sv | 170 +++++++++++++++++
 tb/tb_code_stimulus_gen.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/code_stimulus_gen.sv
`default_nettype none
// ============================================================================
// Module      : code_stimulus_gen
// Description : Stepped 4-bit code generator that drives the a..d inputs of
//               the downstream code converter. Binary or BCD range, up/down
//               counting, parallel load, free-running or single sweep, and
//               step/wrap strobes for sampling the converter outputs.
// Revision    : 1.0 - initial release
// ============================================================================
module code_stimulus_gen #(
   parameter int DIV = 50
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic       stop,
   input  logic       cont,
   input  logic       en,
   input  logic       up,
   input  logic       bcd_mode,
   input  logic       load,
   input  logic [3:0] load_val,
   output logic       a,
   output logic       b,
   output logic       c,
   output logic       d,
   output logic       step,
   output logic       tc,
   output logic       busy,
   output logic       done
);

   // Prescaler terminal count, sized to the fixed 10-bit prescaler.
   localparam logic [9:0] C_DIV_LAST = 10'(DIV - 1);
   localparam logic [3:0] C_TOP_BCD  = 4'd9;
   localparam logic [3:0] C_TOP_BIN  = 4'd15;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t     r_state;
   state_t     w_state_nxt;
   logic [3:0] r_code;
   logic [3:0] w_code_nxt;
   logic [9:0] r_presc;
   logic [9:0] w_presc_nxt;
   logic       r_step;
   logic       w_step_nxt;
   logic       r_tc;
   logic       w_tc_nxt;

   logic [3:0] w_top;
   logic       w_tick;
   logic [3:0] w_load_code;
   logic [3:0] w_stepped_code;
   logic       w_wrap;

   assign w_top  = bcd_mode ? C_TOP_BCD : C_TOP_BIN;
   assign w_tick = (r_state == ST_RUN) && en && (r_presc == C_DIV_LAST);

   // Loaded values outside the BCD range saturate at the BCD top.
   assign w_load_code = (bcd_mode && (load_val > C_TOP_BCD)) ? C_TOP_BCD : load_val;

   // Next code for a step; an out-of-range code counting down snaps to top
   // without being reported as a wrap.
   always_comb begin
      w_stepped_code = r_code;
      w_wrap         = 1'b0;
      if (up) begin
         if (r_code >= w_top) begin
            w_stepped_code = 4'd0;
            w_wrap         = 1'b1;
         end else begin
            w_stepped_code = r_code + 4'd1;
         end
      end else begin
         if (r_code == 4'd0) begin
            w_stepped_code = w_top;
            w_wrap         = 1'b1;
         end else if (r_code > w_top) begin
            w_stepped_code = w_top;
         end else begin
            w_stepped_code = r_code - 4'd1;
         end
      end
   end

   // Next-state, next-code and strobe logic; load beats stop beats everything else.
   always_comb begin
      w_state_nxt = r_state;
      w_code_nxt  = r_code;
      w_step_nxt  = 1'b0;
      w_tc_nxt    = 1'b0;
      if (r_state != ST_RUN) begin
         w_presc_nxt = 10'd0;
      end else if (!en) begin
         w_presc_nxt = r_presc;
      end else if (w_tick) begin
         w_presc_nxt = 10'd0;
      end else begin
         w_presc_nxt = r_presc + 10'd1;
      end

      if (load) begin
         // A tick coinciding with load is dropped; the run restarts its interval.
         w_code_nxt  = w_load_code;
         w_presc_nxt = 10'd0;
      end else if (stop) begin
         w_state_nxt = ST_IDLE;
         w_presc_nxt = 10'd0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (start) begin
                  w_state_nxt = ST_RUN;
               end
            end
            ST_RUN: begin
               if (w_tick) begin
                  w_code_nxt = w_stepped_code;
                  w_step_nxt = 1'b1;
                  w_tc_nxt   = w_wrap;
                  if (w_wrap && !cont) begin
                     w_state_nxt = ST_DONE;
                  end
               end
            end
            ST_DONE: begin
               if (start) begin
                  w_state_nxt = ST_RUN;
               end
            end
            default: begin
               w_state_nxt = ST_IDLE;
            end
         endcase
      end
   end

   // State, code, prescaler and strobe registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
         r_code  <= 4'd0;
         r_presc <= 10'd0;
         r_step  <= 1'b0;
         r_tc    <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_code  <= w_code_nxt;
         r_presc <= w_presc_nxt;
         r_step  <= w_step_nxt;
         r_tc    <= w_tc_nxt;
      end
   end

   assign a    = r_code[0];
   assign b    = r_code[1];
   assign c    = r_code[2];
   assign d    = r_code[3];
   assign step = r_step;
   assign tc   = r_tc;
   assign busy = (r_state == ST_RUN);
   assign done = (r_state == ST_DONE);

endmodule
`default_nettype wire

// File: tb/tb_code_stimulus_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_code_stimulus_gen
// Description : Self-checking bench for code_stimulus_gen with DIV=4.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_code_stimulus_gen;

   localparam int DIV = 4;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start = 1'b0;
   logic       stop = 1'b0;
   logic       cont = 1'b1;
   logic       en = 1'b1;
   logic       up = 1'b1;
   logic       bcd_mode = 1'b0;
   logic       load = 1'b0;
   logic [3:0] load_val = 4'd0;
   logic       a, b, c, d, step, tc, busy, done;
   logic [3:0] code;

   int n_cmp = 0;
   int n_bad = 0;

   assign code = {d, c, b, a};

   code_stimulus_gen #(.DIV(DIV)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (start),
      .stop     (stop),
      .cont     (cont),
      .en       (en),
      .up       (up),
      .bcd_mode (bcd_mode),
      .load     (load),
      .load_val (load_val),
      .a        (a),
      .b        (b),
      .c        (c),
      .d        (d),
      .step     (step),
      .tc       (tc),
      .busy     (busy),
      .done     (done)
   );

   // 10 ns clock.
   always #5 clk = ~clk;

   typedef struct {
      logic       start;
      logic       stop;
      logic       cont;
      logic       en;
      logic       up;
      logic       bcd;
      logic       load;
      logic [3:0] lv;
      int         n;
      logic [3:0] e_code;
      logic       e_step;
      logic       e_tc;
      logic       e_busy;
      logic       e_done;
   } vec_t;

   vec_t tbl[$];

   task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic chk_all(input string tag, input logic [3:0] e_code, input logic e_step,
                          input logic e_tc, input logic e_busy, input logic e_done);
      chk({tag, ".code"}, 8'(code), 8'(e_code));
      chk({tag, ".step"}, 8'(step), 8'(e_step));
      chk({tag, ".tc"},   8'(tc),   8'(e_tc));
      chk({tag, ".busy"}, 8'(busy), 8'(e_busy));
      chk({tag, ".done"}, 8'(done), 8'(e_done));
   endtask

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      // Directed table: BCD down-count, clamped load, out-of-range wrap,
      // load-vs-tick, stop-vs-tick, start+stop together, down snap to top.
      //               st sp ct en up bc ld lv     n  code  s  t  by dn
      tbl.push_back('{0, 0, 1, 1, 0, 1, 1, 4'd4,  1, 4'd4, 0, 0, 0, 0});
      tbl.push_back('{1, 0, 1, 1, 0, 1, 0, 4'd0,  1, 4'd4, 0, 0, 1, 0});
      tbl.push_back('{0, 0, 1, 1, 0, 1, 0, 4'd0,  1, 4'd4, 0, 0, 1, 0});
      tbl.push_back('{0, 0, 1, 1, 0, 1, 0, 4'd0,  3, 4'd3, 1, 0, 1, 0});
      tbl.push_back('{0, 0, 1, 1, 0, 1, 0, 4'd0,  1, 4'd3, 0, 0, 1, 0});
      tbl.push_back('{0, 0, 1, 1, 0, 1, 0, 4'd0,  3, 4'd2, 1, 0, 1, 0});
      tbl.push_back('{0, 0, 1, 1, 0, 1, 0, 4'd0,  4, 4'd1, 1, 0, 1, 0});
      tbl.push_back('{0, 0, 1, 1, 0, 1, 0, 4'd0,  4, 4'd0, 1, 0, 1, 0});
      tbl.push_back('{0, 0, 1, 1, 0, 1, 0, 4'd0,  4, 4'd9, 1, 1, 1, 0});
      tbl.push_back('{0, 0, 1, 1, 0, 1, 0, 4'd0,  4, 4'd8, 1, 0, 1, 0});
      tbl.push_back('{0, 0, 1, 1, 0, 1, 1, 4'd12, 1, 4'd9, 0, 0, 1, 0});
      tbl.push_back('{0, 0, 1, 1, 0, 0, 1, 4'd12, 1, 4'd12,0, 0, 1, 0});
      tbl.push_back('{0, 0, 1, 1, 1, 1, 0, 4'd0,  3, 4'd12,0, 0, 1, 0});
      tbl.push_back('{0, 0, 1, 1, 1, 1, 0, 4'd0,  1, 4'd0, 1, 1, 1, 0});
      tbl.push_back('{0, 0, 1, 1, 1, 1, 0, 4'd0,  3, 4'd0, 0, 0, 1, 0});
      tbl.push_back('{0, 0, 1, 1, 1, 1, 1, 4'd5,  1, 4'd5, 0, 0, 1, 0});
      tbl.push_back('{0, 0, 1, 1, 1, 1, 0, 4'd0,  4, 4'd6, 1, 0, 1, 0});
      tbl.push_back('{0, 0, 1, 1, 1, 1, 0, 4'd0,  3, 4'd6, 0, 0, 1, 0});
      tbl.push_back('{0, 1, 1, 1, 1, 1, 0, 4'd0,  1, 4'd6, 0, 0, 0, 0});
      tbl.push_back('{0, 0, 1, 1, 1, 1, 0, 4'd0,  2, 4'd6, 0, 0, 0, 0});
      tbl.push_back('{1, 1, 1, 1, 1, 1, 0, 4'd0,  1, 4'd6, 0, 0, 0, 0});
      tbl.push_back('{0, 0, 1, 1, 1, 1, 0, 4'd0,  1, 4'd6, 0, 0, 0, 0});
      tbl.push_back('{0, 0, 1, 1, 1, 0, 1, 4'd12, 1, 4'd12,0, 0, 0, 0});
      tbl.push_back('{1, 0, 1, 1, 1, 0, 0, 4'd0,  1, 4'd12,0, 0, 1, 0});
      tbl.push_back('{0, 0, 1, 1, 0, 1, 0, 4'd0,  4, 4'd9, 1, 0, 1, 0});
      tbl.push_back('{0, 1, 1, 1, 0, 1, 0, 4'd0,  1, 4'd9, 0, 0, 0, 0});

      // Reset state, checked while reset is held and after release.
      #2;
      chk_all("reset_held", 4'd0, 0, 0, 0, 0);
      #20 rst_n = 1'b1;
      cyc(1);
      chk_all("reset_rel", 4'd0, 0, 0, 0, 0);

      // 1: free-running binary up-count, 4 cycles per code.
      start = 1'b1; cont = 1'b1; up = 1'b1; bcd_mode = 1'b0;
      cyc(1);
      chk_all("t1_start", 4'd0, 0, 0, 1, 0);
      start = 1'b0;
      for (int t = 1; t <= 68; t++) begin
         logic       es;
         logic [3:0] ec;
         cyc(1);
         ec = 4'((t / DIV) % 16);
         es = ((t % DIV) == 0);
         chk($sformatf("t1_code[%0d]", t), 8'(code), 8'(ec));
         chk($sformatf("t1_step[%0d]", t), 8'(step), 8'(es));
         chk($sformatf("t1_tc[%0d]", t),   8'(tc),   8'(es && (ec == 4'd0)));
      end
      stop = 1'b1;
      cyc(1);
      chk_all("t1_stop", 4'd1, 0, 0, 0, 0);
      stop = 1'b0;

      // 2: single sweep from 0, ends in DONE showing 0 with tc.
      load = 1'b1; load_val = 4'd0;
      cyc(1);
      chk_all("t2_load", 4'd0, 0, 0, 0, 0);
      load = 1'b0; cont = 1'b0; start = 1'b1;
      cyc(1);
      chk_all("t2_start", 4'd0, 0, 0, 1, 0);
      start = 1'b0;
      for (int t = 1; t <= 64; t++) begin
         logic       es;
         logic [3:0] ec;
         cyc(1);
         ec = 4'((t / DIV) % 16);
         es = ((t % DIV) == 0);
         chk($sformatf("t2_code[%0d]", t), 8'(code), 8'(ec));
         chk($sformatf("t2_step[%0d]", t), 8'(step), 8'(es));
         chk($sformatf("t2_tc[%0d]", t),   8'(tc),   8'(t == 64));
         chk($sformatf("t2_busy[%0d]", t), 8'(busy), 8'(t != 64));
         chk($sformatf("t2_done[%0d]", t), 8'(done), 8'(t == 64));
      end
      for (int t = 0; t < 8; t++) begin
         cyc(1);
         chk_all($sformatf("t2_hold[%0d]", t), 4'd0, 0, 0, 0, 1);
      end
      start = 1'b1;
      cyc(1);
      chk_all("t2_restart", 4'd0, 0, 0, 1, 0);
      start = 1'b0; stop = 1'b1;
      cyc(1);
      chk_all("t2_stop", 4'd0, 0, 0, 0, 0);
      stop = 1'b0; cont = 1'b1;

      // 3/4: table-driven vectors.
      foreach (tbl[i]) begin
         start    = tbl[i].start;
         stop     = tbl[i].stop;
         cont     = tbl[i].cont;
         en       = tbl[i].en;
         up       = tbl[i].up;
         bcd_mode = tbl[i].bcd;
         load     = tbl[i].load;
         load_val = tbl[i].lv;
         cyc(tbl[i].n);
         chk_all($sformatf("vec[%0d]", i), tbl[i].e_code, tbl[i].e_step,
                 tbl[i].e_tc, tbl[i].e_busy, tbl[i].e_done);
      end
      start = 1'b0; stop = 1'b0; load = 1'b0;

      // 5: en=0 freezes the interval mid-step, then the remainder completes.
      bcd_mode = 1'b0; up = 1'b1; load = 1'b1; load_val = 4'd0;
      cyc(1);
      load = 1'b0; start = 1'b1;
      cyc(1);
      start = 1'b0;
      cyc(2);
      chk_all("t5_pre", 4'd0, 0, 0, 1, 0);
      en = 1'b0;
      for (int t = 0; t < 10; t++) begin
         cyc(1);
         chk_all($sformatf("t5_frz[%0d]", t), 4'd0, 0, 0, 1, 0);
      end
      en = 1'b1;
      cyc(1);
      chk_all("t5_res1", 4'd0, 0, 0, 1, 0);
      cyc(1);
      chk_all("t5_res2", 4'd1, 1, 0, 1, 0);
      start = 1'b1; stop = 1'b1;
      cyc(1);
      chk_all("t5_stst", 4'd1, 0, 0, 0, 0);
      start = 1'b0; stop = 1'b0;

      // 6: asynchronous reset between edges while running at code 7.
      load = 1'b1; load_val = 4'd7;
      cyc(1);
      load = 1'b0; start = 1'b1;
      cyc(1);
      start = 1'b0;
      cyc(2);
      chk_all("t6_run", 4'd7, 0, 0, 1, 0);
      #2 rst_n = 1'b0;
      #1;
      chk_all("t6_async", 4'd0, 0, 0, 0, 0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      for (int t = 0; t < 8; t++) begin
         cyc(1);
         chk_all($sformatf("t6_idle[%0d]", t), 4'd0, 0, 0, 0, 0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
